// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types, constants and helpers for the pipeline hazard
// controller.
//   fwd_sel_t   - execute-stage operand source select
//   mdu_state_t - MDU sequencer states
//   MDU_CNT_W   - width of the MDU latency counter
//   reg_match() - register-id comparator that never matches $zero
//   fwd_sel()   - E-stage forward select with M-over-W priority
package hazard_pkg;

  localparam int MDU_CNT_W = 4;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,  // register file value
    FWD_WB  = 2'b01,  // result_W
    FWD_MEM = 2'b10   // alu_out_M
  } fwd_sel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_t;

  // $zero is hard-wired, so a producer writing it never creates a hazard.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // The M stage holds the younger result, so it wins over W.
  function automatic fwd_sel_t fwd_sel(input logic [4:0] src,
                                       input logic       rw_m,
                                       input logic [4:0] id_m,
                                       input logic       rw_w,
                                       input logic [4:0] id_w);
    if (rw_m && reg_match(src, id_m)) return FWD_MEM;
    else if (rw_w && reg_match(src, id_w)) return FWD_WB;
    else return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: bundle between the datapath and the hazard controller.
//   master - datapath side: drives register ids / enables, receives controls
//   slave  - hazard_ctrl side: receives pipeline state, drives controls
// Signals:
//   rs_D, rt_D, branch_D                   decode-stage sources / branch flag
//   rs_E, rt_E                             execute-stage sources
//   reg_id_{E,M,W}, reg_write_{E,M,W}      destination ids / write enables
//   mem_to_reg_E, mem_to_reg_M             load in E / M
//   mdu_start_E                            mult/div op in E
//   forwardA_E, forwardB_E                 E operand selects
//   forwardA_D, forwardB_D                 D compare operand takes alu_out_M
//   stall_F, stall_D, stall_E              hold stage registers
//   flush_E, flush_M                       bubble stage registers
//   mdu_busy, mdu_done                     MDU sequencer status
interface hazard_ctrl_if;
  import hazard_pkg::*;

  logic [4:0] rs_D;
  logic [4:0] rt_D;
  logic       branch_D;
  logic [4:0] rs_E;
  logic [4:0] rt_E;
  logic [4:0] reg_id_E;
  logic [4:0] reg_id_M;
  logic [4:0] reg_id_W;
  logic       reg_write_E;
  logic       reg_write_M;
  logic       reg_write_W;
  logic       mem_to_reg_E;
  logic       mem_to_reg_M;
  logic       mdu_start_E;

  fwd_sel_t   forwardA_E;
  fwd_sel_t   forwardB_E;
  logic       forwardA_D;
  logic       forwardB_D;
  logic       stall_F;
  logic       stall_D;
  logic       stall_E;
  logic       flush_E;
  logic       flush_M;
  logic       mdu_busy;
  logic       mdu_done;

  modport master (
    output rs_D, rt_D, branch_D, rs_E, rt_E,
           reg_id_E, reg_id_M, reg_id_W,
           reg_write_E, reg_write_M, reg_write_W,
           mem_to_reg_E, mem_to_reg_M, mdu_start_E,
    input  forwardA_E, forwardB_E, forwardA_D, forwardB_D,
           stall_F, stall_D, stall_E, flush_E, flush_M,
           mdu_busy, mdu_done
  );

  modport slave (
    input  rs_D, rt_D, branch_D, rs_E, rt_E,
           reg_id_E, reg_id_M, reg_id_W,
           reg_write_E, reg_write_M, reg_write_W,
           mem_to_reg_E, mem_to_reg_M, mdu_start_E,
    output forwardA_E, forwardB_E, forwardA_D, forwardB_D,
           stall_F, stall_D, stall_E, flush_E, flush_M,
           mdu_busy, mdu_done
  );

endinterface

// File: rtl/mdu_timer.sv
// mdu_timer: fixed-latency sequencer for the multi-cycle mult/div unit.
// An op entering E stalls the front of the pipe for MDU_LAT cycles, then
// spends one DONE cycle in E while its result is valid before leaving.
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   i_mdu_start   MDU op present in E
//   o_mdu_stall   hold F/D/E and bubble M this cycle
//   o_mdu_busy    sequencer not IDLE
//   o_mdu_done    one-cycle pulse, result valid, op leaves E
module mdu_timer
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_mdu_start,
  output logic o_mdu_stall,
  output logic o_mdu_busy,
  output logic o_mdu_done
);

  localparam logic [MDU_CNT_W-1:0] CNT_INIT = MDU_CNT_W'(MDU_LAT - 1);

  mdu_state_t           r_state;
  logic [MDU_CNT_W-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_mdu_start) begin
            r_cnt   <= CNT_INIT;
            r_state <= (MDU_LAT == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == MDU_CNT_W'(1)) r_state <= DONE;
        end
        // The op still sitting in E keeps mdu_start_E high here; it is the
        // same op leaving, not a new one, so it is ignored.
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // The stall starts in the very cycle the op enters E (state still IDLE),
  // so the IDLE term is combinational on i_mdu_start. Reset forces all
  // outputs low even while the state register has not yet been cleared.
  assign o_mdu_stall = !reset && ((r_state == IDLE && i_mdu_start) || r_state == BUSY);
  assign o_mdu_busy  = !reset && (r_state != IDLE);
  assign o_mdu_done  = !reset && (r_state == DONE);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage MIPS core.
// Produces E-stage forwarding selects, D-stage branch-compare forwards,
// load-use / branch-operand stalls and MDU multi-cycle stalls.
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   bus         hazard_ctrl_if.slave: pipeline state in, stall/flush/forward out
// Parameters:
//   MDU_LAT     cycles an MDU op stalls the pipe in E (1..15)
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_if.slave       bus
);

  logic w_mdu_stall;
  logic w_mdu_busy;
  logic w_mdu_done;
  logic w_lw_stall;
  logic w_br_stall;
  logic w_d_uses_e;
  logic w_d_uses_m;

  mdu_timer #(
    .MDU_LAT (MDU_LAT)
  ) u_mdu_timer (
    .clk         (clk),
    .reset       (reset),
    .i_mdu_start (bus.mdu_start_E),
    .o_mdu_stall (w_mdu_stall),
    .o_mdu_busy  (w_mdu_busy),
    .o_mdu_done  (w_mdu_done)
  );

  // Does the instruction in D read the destination of E / M?
  assign w_d_uses_e = reg_match(bus.reg_id_E, bus.rs_D) || reg_match(bus.reg_id_E, bus.rt_D);
  assign w_d_uses_m = reg_match(bus.reg_id_M, bus.rs_D) || reg_match(bus.reg_id_M, bus.rt_D);

  assign w_lw_stall = bus.mem_to_reg_E && w_d_uses_e;

  // The branch compares in D, so an ALU result still in E is not yet
  // forwardable and a load in M has not yet returned its data.
  assign w_br_stall = bus.branch_D &&
                      ((bus.reg_write_E && w_d_uses_e) ||
                       (bus.mem_to_reg_M && w_d_uses_m));

  // Forward selects ignore stalls: the datapath simply discards them when
  // the stage is held.
  assign bus.forwardA_E = reset ? FWD_REG
                                : fwd_sel(bus.rs_E, bus.reg_write_M, bus.reg_id_M,
                                          bus.reg_write_W, bus.reg_id_W);
  assign bus.forwardB_E = reset ? FWD_REG
                                : fwd_sel(bus.rt_E, bus.reg_write_M, bus.reg_id_M,
                                          bus.reg_write_W, bus.reg_id_W);
  assign bus.forwardA_D = !reset && bus.reg_write_M && reg_match(bus.rs_D, bus.reg_id_M);
  assign bus.forwardB_D = !reset && bus.reg_write_M && reg_match(bus.rt_D, bus.reg_id_M);

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    bus.stall_F = 1'b0;
    bus.stall_D = 1'b0;
    bus.stall_E = 1'b0;
    bus.flush_E = 1'b0;
    bus.flush_M = 1'b0;
    if (reset) begin
      // all controls idle while reset is held
    end else if (w_mdu_stall) begin
      // E is held with the MDU op, so the hole opens up in M instead.
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.stall_E = 1'b1;
      bus.flush_M = 1'b1;
    end else if (w_lw_stall || w_br_stall) begin
      bus.stall_F = 1'b1;
      bus.stall_D = 1'b1;
      bus.flush_E = 1'b1;
    end
  end

  assign bus.mdu_busy = w_mdu_busy;
  assign bus.mdu_done = w_mdu_done;

endmodule
